// File: rtl/vpg_mode_sequencer_if.sv
// Mode-select / lock handshake bundle between the operator side and the sequencer.
interface vpg_mode_sequencer_if;
  logic [3:0] mode_sel;
  logic       pll_locked;
  logic [3:0] mode;
  logic       mode_change;
  logic       vpg_reset;
  logic       busy;
  logic       lock_error;

  // Driver of the raw selection and lock indicator
  modport master (
    output mode_sel, pll_locked,
    input  mode, mode_change, vpg_reset, busy, lock_error
  );

  // Sequencer side
  modport slave (
    input  mode_sel, pll_locked,
    output mode, mode_change, vpg_reset, busy, lock_error
  );
endinterface

// File: rtl/vpg_mode_sequencer.sv
// Debounces the operator mode selection, pulses mode_change to the PLL
// controller and holds the timing generator in reset until the PLL relocks.
module vpg_mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES   = 4096,
  parameter int unsigned LOCK_STABLE     = 256,
  parameter int unsigned LOCK_TIMEOUT    = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  vpg_mode_sequencer_if.slave   seq_if
);

  // One shared sequence counter serves DEBOUNCE, PULSE and SETTLE
  localparam int unsigned SEQ_MAX =
    (DEBOUNCE_CYCLES > PULSE_CYCLES) ?
      ((DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES) :
      ((PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES);
  localparam int unsigned CNT_W = $clog2(SEQ_MAX) + 1;
  localparam int unsigned STB_W = $clog2(LOCK_STABLE) + 1;
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST    = STB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PULSE,
    ST_SETTLE,
    ST_WAIT_LOCK
  } state_e;

  state_e           state_q;
  logic [3:0]       sel_meta_q;
  logic [3:0]       sel_s_q;
  logic             lock_meta_q;
  logic             lock_s_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [STB_W-1:0] stable_q;
  logic [TMO_W-1:0] tmo_q;
  logic             init_q;
  logic [3:0]       mode_q;
  logic             mode_change_q;
  logic             vpg_reset_q;
  logic             busy_q;
  logic             lock_error_q;

  logic             cand_match_c;
  logic             stable_done_c;
  logic             tmo_done_c;

  assign cand_match_c  = (sel_s_q == cand_q);
  assign stable_done_c = lock_s_q && (stable_q == STB_LAST);
  assign tmo_done_c    = (tmo_q == TMO_LAST);

  // Two-flop synchronizers for the asynchronous switch and lock inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_meta_q  <= '0;
      sel_s_q     <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      sel_meta_q  <= seq_if.mode_sel;
      sel_s_q     <= sel_meta_q;
      lock_meta_q <= seq_if.pll_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_DEBOUNCE;
      cand_q        <= '0;
      cnt_q         <= '0;
      stable_q      <= '0;
      tmo_q         <= '0;
      init_q        <= 1'b1;
      mode_q        <= '0;
      mode_change_q <= 1'b0;
      vpg_reset_q   <= 1'b1;
      busy_q        <= 1'b1;
      lock_error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Lock loss while running takes priority over a pending selection
          if (!lock_s_q && !vpg_reset_q) begin
            vpg_reset_q <= 1'b1;
            stable_q    <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT_LOCK;
          end else if (sel_s_q != mode_q) begin
            cand_q  <= sel_s_q;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_DEBOUNCE;
          end
        end

        ST_DEBOUNCE: begin
          if (!cand_match_c) begin
            cand_q <= sel_s_q;
            cnt_q  <= '0;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q <= '0;
            if ((cand_q == mode_q) && !init_q) begin
              // Bounced back to the current mode: nothing to reprogram
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              mode_q      <= cand_q;
              vpg_reset_q <= 1'b1;
              init_q      <= 1'b0;
              state_q     <= ST_PULSE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_PULSE: begin
          // mode_change rises one edge after mode updates
          if (cnt_q == PULSE_LAST) begin
            mode_change_q <= 1'b0;
            cnt_q         <= '0;
            state_q       <= ST_SETTLE;
          end else begin
            mode_change_q <= 1'b1;
            cnt_q         <= cnt_q + CNT_W'(1);
          end
        end

        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q    <= '0;
            stable_q <= '0;
            tmo_q    <= '0;
            state_q  <= ST_WAIT_LOCK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          tmo_q    <= tmo_q + TMO_W'(1);
          stable_q <= lock_s_q ? (stable_q + STB_W'(1)) : '0;
          if (stable_done_c) begin
            vpg_reset_q  <= 1'b0;
            lock_error_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else if (tmo_done_c) begin
            // Leave vpg_reset asserted; the next accepted selection retries
            lock_error_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign seq_if.mode        = mode_q;
  assign seq_if.mode_change = mode_change_q;
  assign seq_if.vpg_reset   = vpg_reset_q;
  assign seq_if.busy        = busy_q;
  assign seq_if.lock_error  = lock_error_q;

endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// Directed and randomized bench for vpg_mode_sequencer.
// Expected event cycles come from the timing rules: a selection settles
// 2 (sync) + 1 + DEBOUNCE cycles after the last pin change, the pulse
// follows one edge later, and vpg_reset falls LOCK_STABLE cycles after the
// synchronized lock last rose (never earlier than PULSE+SETTLE+STABLE+1).
module tb_vpg_mode_sequencer;

  localparam int unsigned DEB = 8;
  localparam int unsigned PUL = 4;
  localparam int unsigned SET = 16;
  localparam int unsigned STB = 4;
  localparam int unsigned TMO = 64;

  // Derived latencies relative to the last pin change
  localparam int LAT_MODE = 2 + 1 + DEB;           // 11
  localparam int LAT_VR   = PUL + SET + STB + 1;   // 25 after mode update
  localparam int LAT_WAIT = PUL + SET + 1;         // WAIT_LOCK entry after mode update

  logic clk = 1'b0;
  logic reset;

  vpg_mode_sequencer_if sif ();

  vpg_mode_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .PULSE_CYCLES    (PUL),
    .SETTLE_CYCLES   (SET),
    .LOCK_STABLE     (STB),
    .LOCK_TIMEOUT    (TMO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .seq_if (sif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Event log, cycle numbers relative to the last clear_log
  int cyc;
  int mode_upd_first, mode_upd_last, mode_upd_cnt;
  int mc_first, mc_last, mc_cnt;
  int vr_fall, vr_rise, busy_fall, err_rise, err_fall, mode_bad;
  logic [3:0] prev_mode;
  logic prev_mc, prev_vr, prev_busy, prev_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic clear_log();
    cyc = 0;
    mode_upd_first = -1; mode_upd_last = -1; mode_upd_cnt = 0;
    mc_first = -1; mc_last = -1; mc_cnt = 0;
    vr_fall = -1; vr_rise = -1; busy_fall = -1; err_rise = -1; err_fall = -1;
    mode_bad = 0;
    prev_mode = sif.mode; prev_mc = sif.mode_change; prev_vr = sif.vpg_reset;
    prev_busy = sif.busy; prev_err = sif.lock_error;
  endtask

  // One clock, sampled 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sif.mode !== prev_mode) begin
      if (prev_mc === 1'b1 || sif.mode_change === 1'b1) mode_bad++;
      if (mode_upd_first < 0) mode_upd_first = cyc;
      mode_upd_last = cyc;
      mode_upd_cnt++;
    end
    if (sif.mode_change === 1'b1) begin
      if (mc_first < 0) mc_first = cyc;
      mc_last = cyc;
      mc_cnt++;
    end
    if (prev_vr === 1'b1 && sif.vpg_reset === 1'b0) vr_fall = cyc;
    if (prev_vr === 1'b0 && sif.vpg_reset === 1'b1 && vr_rise < 0) vr_rise = cyc;
    if (prev_busy === 1'b1 && sif.busy === 1'b0) busy_fall = cyc;
    if (prev_err === 1'b0 && sif.lock_error === 1'b1) err_rise = cyc;
    if (prev_err === 1'b1 && sif.lock_error === 1'b0) err_fall = cyc;
    prev_mode = sif.mode; prev_mc = sif.mode_change; prev_vr = sif.vpg_reset;
    prev_busy = sif.busy; prev_err = sif.lock_error;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"}, 32'(sif.mode), 0);
    chk({tag, "_mc"},   32'(sif.mode_change), 0);
    chk({tag, "_vr"},   32'(sif.vpg_reset), 1);
    chk({tag, "_busy"}, 32'(sif.busy), 1);
    chk({tag, "_err"},  32'(sif.lock_error), 0);
  endtask

  // Full program sequence with a steady lock, mode update at cycle LAT_MODE
  task automatic chk_full_seq(input string tag, input int exp_mode);
    chk({tag, "_mode_at"},   32'(mode_upd_first), LAT_MODE);
    chk({tag, "_mode"},      32'(sif.mode), 32'(exp_mode));
    chk({tag, "_mc_first"},  32'(mc_first), LAT_MODE + 1);
    chk({tag, "_mc_last"},   32'(mc_last), LAT_MODE + PUL);
    chk({tag, "_mc_cnt"},    32'(mc_cnt), PUL);
    chk({tag, "_vr_fall"},   32'(vr_fall), LAT_MODE + LAT_VR);
    chk({tag, "_busy_fall"}, 32'(busy_fall), LAT_MODE + LAT_VR);
  endtask

  int         model_mode;
  logic [3:0] pin_sel, m;
  int         k, c, u, r, d, b, exp_vr;
  bit         seq, drop;

  initial begin
    // Power-up
    reset = 1'b1;
    sif.mode_sel = 4'd3;
    sif.pll_locked = 1'b1;
    observe(3);
    chk_reset_vals("rst_hold");
    reset = 1'b0;
    clear_log();
    observe(40);
    chk_full_seq("pwrup", 3);
    chk("pwrup_err", 32'(sif.lock_error), 0);

    // Bounce rejection: 3 -> 5 -> 3 -> 5 -> 3 every 4 cycles
    clear_log();
    sif.mode_sel = 4'd5; observe(4);
    sif.mode_sel = 4'd3; observe(4);
    sif.mode_sel = 4'd5; observe(4);
    sif.mode_sel = 4'd3; observe(30);
    chk("bounce_mc_cnt", 32'(mc_cnt), 0);
    chk("bounce_mode_cnt", 32'(mode_upd_cnt), 0);
    chk("bounce_vr_rise", 32'(vr_rise), -1);
    chk("bounce_vr", 32'(sif.vpg_reset), 0);
    chk("bounce_busy", 32'(sif.busy), 0);

    // Mode change with lock dropped during SETTLE for 20 cycles
    clear_log();
    sif.mode_sel = 4'd5;
    observe(20);
    sif.pll_locked = 1'b0;
    observe(20);
    sif.pll_locked = 1'b1;
    observe(20);
    chk("chg_mode_at", 32'(mode_upd_first), LAT_MODE);
    chk("chg_mode", 32'(sif.mode), 5);
    chk("chg_mc_cnt", 32'(mc_cnt), PUL);
    chk("chg_mode_bad", 32'(mode_bad), 0);
    chk("chg_vr_fall", 32'(vr_fall), 40 + 2 + STB);

    // Lock glitch then permanent loss -> timeout
    clear_log();
    sif.mode_sel = 4'd9;
    observe(LAT_MODE + LAT_WAIT + 1);
    sif.pll_locked = 1'b0;
    observe(70);
    chk("tmo_mode", 32'(sif.mode), 9);
    chk("tmo_err_rise", 32'(err_rise), LAT_MODE + LAT_WAIT + TMO);
    chk("tmo_busy_fall", 32'(busy_fall), LAT_MODE + LAT_WAIT + TMO);
    chk("tmo_vr_fall", 32'(vr_fall), -1);
    chk("tmo_vr", 32'(sif.vpg_reset), 1);

    // Retry with a new selection clears the error
    clear_log();
    sif.mode_sel = 4'd10;
    sif.pll_locked = 1'b1;
    observe(45);
    chk_full_seq("retry", 10);
    chk("retry_err_fall", 32'(err_fall), LAT_MODE + LAT_VR);
    chk("retry_err", 32'(sif.lock_error), 0);

    // Changes while busy: 5 then 7 during the pulse
    clear_log();
    sif.mode_sel = 4'd5;
    observe(LAT_MODE + 2);
    sif.mode_sel = 4'd7;
    observe(67);
    chk("busy_upd_cnt", 32'(mode_upd_cnt), 2);
    chk("busy_first", 32'(mode_upd_first), LAT_MODE);
    chk("busy_second", 32'(mode_upd_last), LAT_MODE + LAT_VR + 1 + DEB);
    chk("busy_mode", 32'(sif.mode), 7);
    chk("busy_mc_cnt", 32'(mc_cnt), 2 * PUL);
    chk("busy_mc_last", 32'(mc_last), LAT_MODE + LAT_VR + 1 + DEB + PUL);
    chk("busy_vr_fall", 32'(vr_fall), LAT_MODE + LAT_VR + 1 + DEB + LAT_VR);
    chk("busy_mode_bad", 32'(mode_bad), 0);

    // Reset asserted during SETTLE, then power-up sequence repeats
    clear_log();
    sif.mode_sel = 4'd2;
    observe(20);
    reset = 1'b1;
    observe(1);
    chk_reset_vals("rst_mid");
    reset = 1'b0;
    clear_log();
    observe(40);
    chk_full_seq("rst_rep", 2);

    // Lock loss in IDLE
    clear_log();
    sif.pll_locked = 1'b0;
    observe(5);
    chk("loss_vr_rise", 32'(vr_rise), 3);
    chk("loss_busy", 32'(sif.busy), 1);
    sif.pll_locked = 1'b1;
    observe(15);
    chk("loss_vr_fall", 32'(vr_fall), 5 + 2 + STB);
    chk("loss_mc_cnt", 32'(mc_cnt), 0);
    chk("loss_mode_cnt", 32'(mode_upd_cnt), 0);
    chk("loss_mode", 32'(sif.mode), 2);

    // Randomized selections with bounces and lock drops during SETTLE
    model_mode = 2;
    pin_sel = 4'd2;
    for (int it = 0; it < 8; it++) begin
      clear_log();
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        pin_sel = pin_sel + 4'($urandom_range(1, 15));
        sif.mode_sel = pin_sel;
        observe($urandom_range(1, DEB - 1));
      end
      m = pin_sel + 4'($urandom_range(1, 15));
      if (k > 0 && $urandom_range(0, 3) == 0 && pin_sel != 4'(model_mode)) m = 4'(model_mode);
      pin_sel = m;
      c = cyc;
      sif.mode_sel = m;
      seq = (32'(m) != 32'(model_mode));
      drop = seq && ($urandom_range(0, 1) == 1);
      u = c + LAT_MODE;
      exp_vr = seq ? (u + LAT_VR) : -1;
      if (drop) begin
        r = $urandom_range(0, 10);
        d = $urandom_range(1, 20);
        observe(u + PUL + 1 + r - cyc);
        sif.pll_locked = 1'b0;
        observe(d);
        sif.pll_locked = 1'b1;
        b = cyc;
        if (b + 2 + STB > exp_vr) exp_vr = b + 2 + STB;
      end
      observe(c + 70 - cyc);
      chk("rnd_mode", 32'(sif.mode), 32'(m));
      chk("rnd_mode_at", 32'(mode_upd_first), seq ? u : -1);
      chk("rnd_mc_first", 32'(mc_first), seq ? u + 1 : -1);
      chk("rnd_mc_cnt", 32'(mc_cnt), seq ? PUL : 0);
      chk("rnd_vr_fall", 32'(vr_fall), 32'(exp_vr));
      chk("rnd_vr", 32'(sif.vpg_reset), 0);
      chk("rnd_busy", 32'(sif.busy), 0);
      chk("rnd_mode_bad", 32'(mode_bad), 0);
      model_mode = int'(m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
